// File: rtl/stack_arbiter_pkg.sv
// Shared types for the stack arbiter: sequencer states and request op codes.
package stack_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after a rotating
// pointer; the pointer moves past the winner when the grant is consumed.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     advance,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     gnt_valid
);

  localparam int unsigned IDW = $clog2(N_REQ);

  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_cand;
  logic [IDW-1:0] w_ptr_next;

  // Scan N_REQ slots starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    w_cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_cand = (IDW+1)'(r_ptr) + (IDW+1)'(i);
      if (w_cand >= (IDW+1)'(N_REQ)) begin
        w_cand = w_cand - (IDW+1)'(N_REQ);
      end
      if (!gnt_valid && req[w_cand[IDW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_id    = w_cand[IDW-1:0];
      end
    end
  end

  assign w_ptr_next = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (advance && gnt_valid) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between N_REQ requesters through a round-robin
// IDLE -> ISSUE -> RESP sequencer that never pushes on full or pops on empty.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned ADDR_SPACE_EXP = 4,
  parameter int unsigned N_REQ          = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_op,
  input  logic [N_REQ*DATA_SIZE-1:0] req_wdata,
  output logic [N_REQ-1:0]           req_done,
  output logic                       req_err,
  output logic [DATA_SIZE-1:0]       rsp_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [ADDR_SPACE_EXP:0]    level,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [DATA_SIZE-1:0]       stk_push_data,
  input  logic [DATA_SIZE-1:0]       stk_pop_data,
  input  logic                       stk_empty,
  input  logic                       stk_full
);

  localparam int unsigned IDW   = $clog2(N_REQ);
  localparam int unsigned LVLW  = ADDR_SPACE_EXP + 1;
  localparam logic [LVLW-1:0] DEPTH = LVLW'(2 ** ADDR_SPACE_EXP);

  state_e                r_state;
  state_e                w_next;
  logic [IDW-1:0]        r_grant_id;
  op_e                   r_op;
  logic [DATA_SIZE-1:0]  r_wdata;
  logic                  r_err;
  logic [LVLW-1:0]       r_level;
  logic [DATA_SIZE-1:0]  r_rsp_data;
  logic [IDW-1:0]        w_gnt_id;
  logic                  w_gnt_valid;
  logic                  w_advance;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .advance   (w_advance),
    .gnt_id    (w_gnt_id),
    .gnt_valid (w_gnt_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes and done are decoded from the state so a reset drops them at once.
  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    req_done  = '0;
    req_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_advance = 1'b1;
          w_next    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_next = ST_RESP;
        if (r_op == OP_PUSH) begin
          stk_push = !stk_full;
        end else begin
          stk_pop  = !stk_empty;
        end
      end
      ST_RESP: begin
        w_next               = ST_IDLE;
        req_done[r_grant_id] = 1'b1;
        req_err              = r_err;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, error flag, popped data and saturating occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_id <= '0;
      r_op       <= OP_PUSH;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_level    <= '0;
      r_rsp_data <= '0;
    end else begin
      if (r_state == ST_IDLE && w_gnt_valid) begin
        r_grant_id <= w_gnt_id;
        r_op       <= op_e'(req_op[w_gnt_id]);
        r_wdata    <= req_wdata[int'(w_gnt_id) * int'(DATA_SIZE) +: DATA_SIZE];
      end
      if (r_state == ST_ISSUE) begin
        r_err <= !(stk_push || stk_pop);
        if (stk_pop) begin
          r_rsp_data <= stk_pop_data;
        end
        if (stk_push && r_level != DEPTH) begin
          r_level <= r_level + LVLW'(1);
        end else if (stk_pop && r_level != '0) begin
          r_level <= r_level - LVLW'(1);
        end
      end
    end
  end

  assign grant_id      = r_grant_id;
  assign busy          = (r_state != ST_IDLE);
  assign level         = r_level;
  assign rsp_data      = r_rsp_data;
  assign stk_push_data = r_wdata;

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter with a behavioural LIFO attached and a
// queue-based reference model checked on every done pulse.
module tb_stack_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int NR    = 2;
  localparam int DEPTH = 16;

  typedef struct {
    bit           op;
    logic [DW-1:0] d;
  } req_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_op;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_done;
  logic              req_err;
  logic [DW-1:0]     rsp_data;
  logic [0:0]        grant_id;
  logic              busy;
  logic [AW:0]       level;
  logic              stk_push;
  logic              stk_pop;
  logic [DW-1:0]     stk_push_data;
  logic [DW-1:0]     stk_pop_data;
  logic              stk_empty;
  logic              stk_full;

  int n_chk  = 0;
  int n_fail = 0;

  req_t          pend0[$];
  req_t          pend1[$];
  logic [DW-1:0] ref_stk[$];
  int            done_log[$];
  logic [DW-1:0] last_rsp;
  int            pop_strobes = 0;

  always #5 clk = ~clk;

  stack_arbiter #(
    .DATA_SIZE      (DW),
    .ADDR_SPACE_EXP (AW),
    .N_REQ          (NR)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_op        (req_op),
    .req_wdata     (req_wdata),
    .req_done      (req_done),
    .req_err       (req_err),
    .rsp_data      (rsp_data),
    .grant_id      (grant_id),
    .busy          (busy),
    .level         (level),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .stk_push_data (stk_push_data),
    .stk_pop_data  (stk_pop_data),
    .stk_empty     (stk_empty),
    .stk_full      (stk_full)
  );

  // Behavioural LIFO standing in for the stack instance (reset = ~reset_n).
  logic [DW-1:0] smem [DEPTH];
  int            sp;
  assign stk_empty    = (sp == 0);
  assign stk_full     = (sp == DEPTH);
  assign stk_pop_data = (sp > 0) ? smem[sp-1] : '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= 0;
    end else if (stk_push && sp < DEPTH) begin
      smem[sp] <= stk_push_data;
      sp       <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops the requester's pending entry and is
  // checked against a plain queue LIFO of capacity DEPTH.
  always @(negedge clk) begin : monitor
    int            id;
    req_t          r;
    bit            exp_err;
    logic [DW-1:0] exp_d;
    if (reset_n !== 1'b1) begin
      ref_stk.delete();
      last_rsp = '0;
    end else begin
      if (stk_push || stk_pop) begin
        check("strobe_excl", 32'(stk_push & stk_pop), 0);
        check("push_guard", 32'(stk_push & stk_full), 0);
        check("pop_guard", 32'(stk_pop & stk_empty), 0);
      end
      if (stk_pop) pop_strobes++;
      if (req_done != '0) begin
        check("done_onehot", $countones(req_done), 1);
        id = req_done[1] ? 1 : 0;
        done_log.push_back(id);
        check("grant_id", 32'(grant_id), id);
        if ((id == 0 && pend0.size() == 0) || (id == 1 && pend1.size() == 0)) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: req%0d done with nothing pending", id);
        end else begin
          r = (id == 0) ? pend0.pop_front() : pend1.pop_front();
          exp_d = '0;
          if (!r.op) begin
            exp_err = (ref_stk.size() == DEPTH);
            if (!exp_err) ref_stk.push_back(r.d);
          end else begin
            exp_err = (ref_stk.size() == 0);
            if (!exp_err) exp_d = ref_stk.pop_back();
          end
          check("err", 32'(req_err), 32'(exp_err));
          check("level", 32'(level), ref_stk.size());
          if (r.op && !exp_err) begin
            check("rsp_data", 32'(rsp_data), 32'(exp_d));
            last_rsp = exp_d;
          end else begin
            check("rsp_hold", 32'(rsp_data), 32'(last_rsp));
          end
        end
      end
    end
  end

  task automatic enqueue(input int id, input bit op, input logic [DW-1:0] d);
    req_t r;
    r.op = op;
    r.d  = d;
    if (id == 0) pend0.push_back(r);
    else         pend1.push_back(r);
  endtask

  task automatic wait_done(input int id);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_done[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout_done: req%0d never completed", id);
    end
  endtask

  task automatic do_req(input int id, input bit op, input logic [DW-1:0] d);
    enqueue(id, op, d);
    @(posedge clk); #1;
    req_valid[id]          = 1'b1;
    req_op[id]             = op;
    req_wdata[id*DW +: DW] = d;
    wait_done(id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  // Holds the request continuously across n back-to-back completions.
  task automatic burst(input int id, input bit op, input logic [DW-1:0] d, input int n);
    for (int k = 0; k < n; k++) enqueue(id, op, d);
    @(posedge clk); #1;
    req_valid[id]          = 1'b1;
    req_op[id]             = op;
    req_wdata[id*DW +: DW] = d;
    for (int k = 0; k < n; k++) wait_done(id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic rand_proc(input int id, input int nops);
    int bias;
    for (int i = 0; i < nops; i++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      bias = ((i / 100) % 2 == 0) ? 78 : 22;
      do_req(id, ($urandom_range(99) < bias) ? 1'b0 : 1'b1, DW'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int got_stk;
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(req_done), 0);
    check("rst_rsp", 32'(rsp_data), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_strobes", 32'({stk_push, stk_pop}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Push A5 with cycle-exact latency, then pop it back.
    enqueue(0, 1'b0, 8'hA5);
    @(posedge clk); #1;
    req_valid[0]   = 1'b1;
    req_op[0]      = 1'b0;
    req_wdata[7:0] = 8'hA5;
    @(negedge clk);
    check("lat_n_idle", 32'({busy, stk_push}), 0);
    @(negedge clk);
    check("lat_n1_push", 32'(stk_push), 1);
    check("lat_n1_data", 32'(stk_push_data), 32'h A5);
    @(negedge clk);
    check("lat_n2_done", 32'(req_done), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    do_req(0, 1'b1, 8'h00);

    // Pop on empty from req1: error, no pop strobe.
    base = pop_strobes;
    do_req(1, 1'b1, 8'h00);
    check("empty_no_pop", pop_strobes - base, 0);
    check("empty_level", 32'(level), 0);

    // Continuous pushes from both requesters must alternate 0,1,0,1...
    base = done_log.size();
    fork
      burst(0, 1'b0, 8'h11, 4);
      burst(1, 1'b0, 8'h22, 4);
    join
    check("fair_count", done_log.size() - base, 8);
    for (int k = 0; k < 8 && base + k < done_log.size(); k++) begin
      check("fair_order", done_log[base+k], k % 2);
    end
    for (int k = 0; k < 8; k++) do_req(0, 1'b1, 8'h00);

    // Fill to depth, overflow, then drain in LIFO order.
    for (int k = 0; k < 16; k++) do_req(0, 1'b0, DW'(k));
    check("full_level", 32'(level), 16);
    got_stk = sp;
    do_req(0, 1'b0, 8'h10);
    check("ovf_level", 32'(level), 16);
    check("ovf_stack", sp, got_stk);
    for (int k = 0; k < 16; k++) do_req(0, 1'b1, 8'h00);
    do_req(0, 1'b1, 8'h00);

    // Reset in the middle of an ISSUE cycle of a push.
    do_req(0, 1'b0, 8'h33);
    @(posedge clk); #1;
    req_valid[0]   = 1'b1;
    req_op[0]      = 1'b0;
    req_wdata[7:0] = 8'h55;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (stk_push) begin
          seen = 1'b1;
          break;
        end
      end
      check("rst_mid_issue_seen", 32'(seen), 1);
    end
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_strobes", 32'({stk_push, stk_pop}), 0);
    check("rst_mid_done", 32'(req_done), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_level", 32'(level), 0);
    req_valid = '0;
    pend0.delete();
    pend1.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    base = done_log.size();
    fork
      do_req(1, 1'b0, 8'h44);
      do_req(0, 1'b0, 8'h66);
    join
    check("post_rst_first", (done_log.size() > base) ? done_log[base] : -1, 0);
    do_req(0, 1'b1, 8'h00);
    do_req(1, 1'b1, 8'h00);

    // Randomised mixed traffic from both requesters.
    fork
      rand_proc(0, 500);
      rand_proc(1, 500);
    join

    repeat (5) @(posedge clk);
    check("pend_empty", pend0.size() + pend1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
